router_fifo: RTL

Per-port output buffer of the 1x3 router: one instance sits directly downstream of `router_sync` for each destination port, accepting bytes when its `write_enb` bit is set and returning `full`/`empty` to it. The buffer holds a header marker with every byte so the read side can track packet boundaries. It drives the port's output byte stream and clears itself on `soft_rst` when the destination abandons a packet.

---
 rtl/router_pkg.sv | 27 ++
 rtl/router_fifo.sv | 101 ++++++++++
 2 files changed

// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: datapath width, output buffer depth,
// header field positions and the packet counter sizing.
package router_pkg;

   localparam int DATA_W       = 8;
   localparam int FIFO_DEPTH   = 16;
   localparam int FIFO_ADDR_W  = 4;

   // Header byte layout: payload length in [7:2], destination address in [1:0]
   localparam int HDR_LEN_MSB  = 7;
   localparam int HDR_LEN_LSB  = 2;
   localparam int HDR_ADDR_MSB = 1;
   localparam int HDR_ADDR_LSB = 0;
   localparam int HDR_LEN_W    = HDR_LEN_MSB - HDR_LEN_LSB + 1;

   localparam int PKT_CNT_W    = 7;

   typedef logic [PKT_CNT_W-1:0] pkt_cnt_t;

   // Bytes still to come after a header: payload length plus the parity byte.
   function automatic pkt_cnt_t pkt_len_load(input logic [DATA_W-1:0] hdr);
      pkt_cnt_t len;
      len = pkt_cnt_t'(hdr[HDR_LEN_MSB:HDR_LEN_LSB]);
      return len + pkt_cnt_t'(1);
   endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-port output buffer of the 1x3 router: byte FIFO with a header marker per
// entry and a read-side packet counter that tracks where the current packet ends.
module router_fifo #(
   parameter int DATA_W = router_pkg::DATA_W,
   parameter int DEPTH  = router_pkg::FIFO_DEPTH,
   parameter int ADDR_W = router_pkg::FIFO_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              soft_rst,
   input  logic              we,
   input  logic              re,
   input  logic              lfd_state,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic              pkt_busy
);

   import router_pkg::*;

   localparam int PTR_W = ADDR_W + 1;

   logic [DATA_W:0]       mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   pkt_cnt_t              pkt_cnt_q, pkt_cnt_d;
   logic [DATA_W-1:0]     dout_q, dout_d;

   logic                  wr_acc;
   logic                  rd_acc;
   logic [DATA_W:0]       rd_entry;
   logic                  rd_hdr;
   logic [DATA_W-1:0]     rd_data;

   // Same-address low bits with differing wrap bits distinguishes full from empty
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                  (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

   assign wr_acc = we && !full;
   assign rd_acc = re && !empty;

   assign rd_entry = mem_q[rd_ptr_q[ADDR_W-1:0]];
   assign rd_hdr   = rd_entry[DATA_W];
   assign rd_data  = rd_entry[DATA_W-1:0];

   assign dout     = dout_q;
   assign pkt_busy = (pkt_cnt_q != '0);

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      pkt_cnt_d = pkt_cnt_q;
      dout_d    = dout_q;

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end

      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         dout_d   = rd_data;
         if (rd_hdr) begin
            pkt_cnt_d = pkt_len_load(rd_data);
         end else if (pkt_cnt_q != '0) begin
            pkt_cnt_d = pkt_cnt_q - pkt_cnt_t'(1);
         end
      end else if (pkt_cnt_q == '0) begin
         // Between packets the port idles at zero rather than showing stale data
         dout_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || soft_rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         pkt_cnt_q <= '0;
         dout_q    <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         pkt_cnt_q <= pkt_cnt_d;
         dout_q    <= dout_d;
      end
   end

   // Storage is wiped only by the hard reset; a timeout reset just rewinds pointers
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (!soft_rst && wr_acc) begin
         mem_q[wr_ptr_q[ADDR_W-1:0]] <= {lfd_state, din};
      end
   end

endmodule
